alu_sliced: RTL and testbench

- Parametrised multi-cycle ALU. Processes a WIDTH-bit operand pair one SLICE-bit slice per clock, LSB slice first.
- The carry is propagated correctly between slices. It delivers a full flag set (carry, zero, negative, overflow).
- It sits between an operand source and a result consumer, with valid/ready handshakes on both sides.
- It is the generalised successor to the fixed 8-bit two-slice ALU and uses the same opcode encoding.

---
 rtl/alu_sliced.sv | 184 ++++++++++++++++++
 tb/tb_alu_sliced.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sliced.sv
// ---------------------------------------------------------------------------
// alu_sliced
//
// Multi-cycle ALU that processes a WIDTH-bit operand pair one SLICE-bit slice
// per clock, least-significant slice first, carrying between slices. One
// operation is in flight at a time; a result is held until the consumer takes
// it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair + opcode presented by the source
//   in_ready   block can accept an operation (only in IDLE)
//   a, b       operands (WIDTH bits), sampled at the accept edge only
//   opcode     000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 XOR,
//              110 PASS B, 111 reserved (result 0)
//   out_valid  result and flags valid
//   out_ready  consumer accepts the result
//   result     operation result (WIDTH bits)
//   carry_out  ADD: carry out of MSB; SUB: borrow (A < B unsigned); else 0
//   zero       result == 0
//   negative   result MSB
//   overflow   signed overflow for ADD/SUB; else 0
// ---------------------------------------------------------------------------
module alu_sliced #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0]    LAST  = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOT  = 3'b100,
        OP_XOR  = 3'b101,
        OP_PASS = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    op_t              op_r;
    logic             carry_r;
    logic [WIDTH-1:0] work_r;

    // Per-slice datapath and the values loaded into the outputs on the final
    // slice. The final slice's result is not in work_r yet when the outputs
    // load, so the flags are derived from work_next.
    int unsigned      base;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] bp_s;
    logic [SLICE-1:0] r_s;
    logic [SLICE:0]   sum_s;
    logic             carry_next;
    logic [WIDTH-1:0] work_next;
    logic             is_arith;
    logic             b_msb_eff;
    logic             ovf_next;
    logic             cout_next;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        base       = SLICE * int'(cnt);
        a_s        = SLICE'(a_r >> base);
        b_s        = SLICE'(b_r >> base);
        // SUB is A + ~B + 1: the +1 enters as the initial carry at accept.
        bp_s       = (op_r == OP_SUB) ? ~b_s : b_s;
        sum_s      = {1'b0, a_s} + {1'b0, bp_s} + {{SLICE{1'b0}}, carry_r};
        carry_next = sum_s[SLICE];
        r_s        = '0;
        case (op_r)
            OP_ADD,
            OP_SUB:  r_s = sum_s[SLICE-1:0];
            OP_AND:  r_s = a_s & b_s;
            OP_OR:   r_s = a_s | b_s;
            OP_NOT:  r_s = ~a_s;
            OP_XOR:  r_s = a_s ^ b_s;
            OP_PASS: r_s = b_s;
            default: r_s = '0;
        endcase
        work_next = (work_r & ~(SMASK << base)) | (WIDTH'(r_s) << base);

        is_arith  = (op_r == OP_ADD) || (op_r == OP_SUB);
        b_msb_eff = (op_r == OP_SUB) ? ~b_r[WIDTH-1] : b_r[WIDTH-1];
        ovf_next  = is_arith && (a_r[WIDTH-1] == b_msb_eff)
                             && (work_next[WIDTH-1] != a_r[WIDTH-1]);
        cout_next = 1'b0;
        if (op_r == OP_ADD) cout_next = carry_next;
        if (op_r == OP_SUB) cout_next = ~carry_next;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= OP_ADD;
            carry_r   <= 1'b0;
            work_r    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Also raises in_ready on the first edge after reset.
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        op_r     <= op_t'(opcode);
                        cnt      <= '0;
                        carry_r  <= (opcode == OP_SUB);
                        work_r   <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    work_r  <= work_next;
                    carry_r <= carry_next;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= work_next;
                        zero      <= (work_next == '0);
                        negative  <= work_next[WIDTH-1];
                        carry_out <= cout_next;
                        overflow  <= ovf_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sliced.sv
// ---------------------------------------------------------------------------
// tb_alu_sliced
//
// Self-checking bench for alu_sliced. Three instances: the default 16/4
// configuration for directed scenarios, plus 8/8 and 32/4 for a randomized
// sweep of every opcode against an independent reference model. Expected
// results are queued when an operation is driven and popped when the DUT
// presents its result.
// ---------------------------------------------------------------------------
module tb_alu_sliced;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16/4 instance
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0, result;
    logic [2:0]  opcode = '0;
    logic        carry_out, zero, negative, overflow;

    // 8/8 instance
    logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic [2:0]  op8 = '0;
    logic        c8, z8, n8, v8;

    // 32/4 instance
    logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, result32;
    logic [2:0]  op32 = '0;
    logic        c32, z32, n32, v32;

    alu_sliced #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry_out(carry_out),
        .zero(zero), .negative(negative), .overflow(overflow)
    );

    alu_sliced #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .opcode(op8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .carry_out(c8),
        .zero(z8), .negative(n8), .overflow(v8)
    );

    alu_sliced #(.WIDTH(32), .SLICE(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .opcode(op32), .out_valid(out_valid32),
        .out_ready(out_ready32), .result(result32), .carry_out(c32),
        .zero(z32), .negative(n32), .overflow(v32)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Packed expectation: {result[31:0], carry, zero, negative, overflow}
    logic [35:0] q16[$];
    logic [35:0] q8[$];
    logic [35:0] q32[$];

    function automatic logic [35:0] model(input logic [2:0] op,
                                          input logic [31:0] xa,
                                          input logic [31:0] xb,
                                          input int w);
        logic [32:0] s;
        logic [31:0] m, r, ua, ub;
        logic        c, v;
        m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = xa & m;
        ub = xb & m;
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin
                s = {1'b0, ua} + {1'b0, ub};
                r = s[31:0] & m;
                c = s[w];
                v = (ua[w-1] == ub[w-1]) && (r[w-1] != ua[w-1]);
            end
            3'd1: begin
                r = (ua - ub) & m;
                c = (ua < ub);
                v = (ua[w-1] != ub[w-1]) && (r[w-1] != ua[w-1]);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ~ua & m;
            3'd5: r = ua ^ ub;
            3'd6: r = ub;
            default: r = '0;
        endcase
        return {r, c, (r == 32'd0), r[w-1], v};
    endfunction

    // Wait (bounded) for in_ready, then present one operation for one edge.
    task automatic start16(input logic [2:0] op, input logic [15:0] va,
                           input logic [15:0] vb, input bit push);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL start16_ready: in_ready=%b expected 1 within 50 cycles", in_ready);
        end
        opcode   = op;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        if (push) q16.push_back(model(op, {16'h0, va}, {16'h0, vb}, 16));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the accept edge: measures latency in
    // edges, compares against the scoreboard, optionally completes handshake.
    task automatic collect16(input string name, input bit handshake);
        int          n = 0;
        logic [35:0] got, exp;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n !== 4) $display("FAIL %s_latency: got %0d edges expected 4", name, n);
        else n_pass++;
        got = {16'h0, result, carry_out, zero, negative, overflow};
        exp = (q16.size() > 0) ? q16.pop_front() : 36'hx_xxxx_xxxx;
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got r=%h c%b z%b n%b v%b expected r=%h c%b z%b n%b v%b", name,
                     got[35:4], got[3], got[2], got[1], got[0],
                     exp[35:4], exp[3], exp[2], exp[1], exp[0]);
        else n_pass++;
        if (handshake) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({in_ready, out_valid, result, carry_out, zero, negative, overflow} !== 22'h0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b r=%h c%b z%b n%b v%b expected all 0",
                     in_ready, out_valid, result, carry_out, zero, negative, overflow);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_release_ready: got %b expected 0", in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_first_edge: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_add();
        start16(3'd0, 16'hFFFF, 16'h0001, 1'b1); collect16("add_wrap", 1'b1);
        start16(3'd0, 16'h7FFF, 16'h0001, 1'b1); collect16("add_ovf", 1'b1);
        start16(3'd0, 16'h00FF, 16'h0001, 1'b1); collect16("add_xslice", 1'b1);
    endtask

    task automatic test_sub();
        start16(3'd1, 16'h0003, 16'h0005, 1'b1); collect16("sub_borrow", 1'b1);
        start16(3'd1, 16'h8000, 16'h0001, 1'b1); collect16("sub_ovf", 1'b1);
        start16(3'd1, 16'h1234, 16'h1234, 1'b1); collect16("sub_zero", 1'b1);
    endtask

    task automatic test_logic();
        start16(3'd2, 16'hF0F0, 16'hFF00, 1'b1); collect16("and", 1'b1);
        start16(3'd3, 16'h0F0F, 16'h8000, 1'b1); collect16("or", 1'b1);
        start16(3'd4, 16'h00FF, 16'h1234, 1'b1); collect16("not", 1'b1);
        start16(3'd6, 16'h1111, 16'hC001, 1'b1); collect16("pass_b", 1'b1);
        start16(3'd7, 16'hFFFF, 16'hFFFF, 1'b1); collect16("reserved", 1'b1);
    endtask

    task automatic test_backpressure();
        start16(3'd5, 16'hA5A5, 16'hFFFF, 1'b1);
        collect16("bp_xor", 1'b0);
        // Second operation presented while the first result is held.
        opcode   = 3'd0;
        a        = 16'h0001;
        b        = 16'h0002;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if ({out_valid, in_ready, result} !== {2'b10, 16'h5A5A})
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b r=%h expected vld=1 rdy=0 r=5a5a",
                         i, out_valid, in_ready, result);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if ({out_valid, in_ready, result} !== {2'b01, 16'h5A5A})
            $display("FAIL bp_release: got vld=%b rdy=%b r=%h expected vld=0 rdy=1 r=5a5a",
                     out_valid, in_ready, result);
        else n_pass++;
        q16.push_back(model(3'd0, 32'h1, 32'h2, 16));
        @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_second_accept: in_ready got %b expected 0", in_ready);
        else n_pass++;
        collect16("bp_second", 1'b1);
    endtask

    task automatic test_reset_mid_run();
        start16(3'd0, 16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, result, carry_out, zero, negative, overflow} !== 22'h0)
            $display("FAIL midrun_reset: got rdy=%b vld=%b r=%h c%b z%b n%b v%b expected all 0",
                     in_ready, out_valid, result, carry_out, zero, negative, overflow);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL midrun_ready: got %b expected 1", in_ready);
        else n_pass++;
        start16(3'd0, 16'h1234, 16'h1111, 1'b1);
        collect16("midrun_fresh_add", 1'b1);
    endtask

    task automatic test_sweep8(input int per_op);
        for (int op = 0; op < 8; op++) begin
            for (int i = 0; i < per_op; i++) begin
                int          t = 0;
                int          n = 0;
                logic [35:0] got, exp;
                while (!in_ready8 && t < 50) begin @(negedge clk); t++; end
                op8       = 3'(op);
                a8        = (i % 8 == 0) ? 8'hFF : 8'($urandom);
                b8        = (i % 8 == 1) ? 8'h80 : 8'($urandom);
                in_valid8 = 1'b1;
                q8.push_back(model(op8, {24'h0, a8}, {24'h0, b8}, 8));
                @(negedge clk);
                in_valid8 = 1'b0;
                while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
                n_total++;
                if (n !== 1) $display("FAIL sweep8_latency op%0d: got %0d expected 1", op, n);
                else n_pass++;
                got = {24'h0, result8, c8, z8, n8, v8};
                exp = (q8.size() > 0) ? q8.pop_front() : 36'hx_xxxx_xxxx;
                n_total++;
                if (got !== exp)
                    $display("FAIL sweep8 op%0d: got %h expected %h", op, got, exp);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sweep32(input int per_op);
        for (int op = 0; op < 8; op++) begin
            for (int i = 0; i < per_op; i++) begin
                int          t = 0;
                int          n = 0;
                logic [35:0] got, exp;
                while (!in_ready32 && t < 50) begin @(negedge clk); t++; end
                op32       = 3'(op);
                a32        = (i % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
                b32        = (i % 8 == 1) ? 32'h8000_0000 : $urandom;
                in_valid32 = 1'b1;
                q32.push_back(model(op32, a32, b32, 32));
                @(negedge clk);
                in_valid32 = 1'b0;
                while (!out_valid32 && n < 50) begin @(negedge clk); n++; end
                n_total++;
                if (n !== 8) $display("FAIL sweep32_latency op%0d: got %0d expected 8", op, n);
                else n_pass++;
                got = {result32, c32, z32, n32, v32};
                exp = (q32.size() > 0) ? q32.pop_front() : 36'hx_xxxx_xxxx;
                n_total++;
                if (got !== exp)
                    $display("FAIL sweep32 op%0d: got %h expected %h", op, got, exp);
                else n_pass++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        test_sweep8(150);
        test_sweep32(150);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
